// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
//   8N1 UART transmitter that pops bytes from a registered-read byte FIFO
//   and serializes them LSB first: start bit 0, DATA_BITWIDTH data bits,
//   one stop bit 1.
//
// Ports
//   clk               system clock
//   reset_n           asynchronous active-low reset
//   tx_enable         gates the start of new frames (sampled in IDLE only)
//   fifo_read_ready   FIFO non-empty
//   fifo_read_data    FIFO read data, valid the cycle after the pop strobe
//   fifo_read_enable  one-cycle pop strobe
//   txd               registered serial output, idle high
//   busy              high whenever the FSM is not in IDLE
//   tx_count          completed frames, wraps modulo 2^16
module uart_tx_fifo_reader #(
    parameter int CLK_PER_BIT   = 868,
    parameter int DATA_BITWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tx_enable,
    input  logic                     fifo_read_ready,
    input  logic [DATA_BITWIDTH-1:0] fifo_read_data,
    output logic                     fifo_read_enable,
    output logic                     txd,
    output logic                     busy,
    output logic [15:0]              tx_count
);

    localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITWIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITWIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [BAUD_W-1:0]        r_baud_cnt;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic [DATA_BITWIDTH-1:0] r_shift;
    logic [DATA_BITWIDTH-1:0] w_shift_next;
    logic                     r_txd;
    logic [15:0]              r_tx_count;
    logic                     w_baud_last;
    logic                     w_bit_last;

    assign w_baud_last  = (r_baud_cnt == BAUD_LAST);
    assign w_bit_last   = (r_bit_cnt == BIT_LAST);
    assign w_shift_next = r_shift >> 1;

    assign txd      = r_txd;
    assign tx_count = r_tx_count;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (tx_enable && fifo_read_ready) w_state_next = S_POP;
            S_POP:   w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_START;
            S_START: if (w_baud_last) w_state_next = S_DATA;
            S_DATA:  if (w_baud_last && w_bit_last) w_state_next = S_STOP;
            S_STOP:  if (w_baud_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode: the pop strobe exists only in POP, which is entered
    // solely from IDLE with ready high, so it can never repeat back-to-back.
    always_comb begin
        fifo_read_enable = (r_state == S_POP);
        busy             = (r_state != S_IDLE);
    end

    // Datapath: the line level is registered one edge ahead of each phase,
    // so txd already holds the new bit when the FSM enters that phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_txd      <= 1'b1;
            r_shift    <= '0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_count <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    // Read data is valid here, one cycle after the POP strobe.
                    r_shift    <= fifo_read_data;
                    r_baud_cnt <= '0;
                    r_txd      <= 1'b0;
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_txd      <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_shift    <= w_shift_next;
                        r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                        r_txd      <= w_bit_last ? 1'b1 : w_shift_next[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_tx_count <= r_tx_count + 16'd1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                    r_txd <= 1'b1;
                end
                default: begin
                    r_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
- UART transmitter that drains the read side of the team's BRAM-backed byte FIFO and serializes each popped byte onto txd.
- Format is 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
- Sits between the CPU's output FIFO and the board TX pin; it is the consumer end of the FIFO read handshake.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal values >= 2.
- DATA_BITWIDTH, 8, FIFO word width and UART payload bits.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- tx_enable  input  1  when 0, no new frame starts; an in-flight frame completes
- fifo_read_ready  input  1  FIFO non-empty
- fifo_read_data  input  DATA_BITWIDTH  FIFO registered read data
- fifo_read_enable  output  1  one-cycle pop strobe to FIFO
- txd  output  1  serial line, idle high
- busy  output  1  high whenever state != IDLE
- tx_count  output  16  frames completed, wraps modulo 2^16

Behaviour:
- Reset: asynchronous, active-low, one clock. Reset values: state = IDLE, txd = 1, fifo_read_enable = 0, busy = 0, tx_count = 0, shift register = 0, baud and bit counters = 0.
- Reset asserted mid-frame: txd returns to 1 immediately and the partial frame is abandoned. The popped byte is lost; this is not an error.
- FIFO read timing (fixed): the pop strobe increments the read pointer. The popped word appears on fifo_read_data in the cycle after the strobe.
- State machine, one transition per clock unless noted:
  - IDLE: if tx_enable & fifo_read_ready, go to POP; otherwise stay. txd = 1.
  - POP: fifo_read_enable = 1 for exactly this cycle, then go to LOAD.
  - LOAD: capture fifo_read_data into the shift register, clear the baud counter, drive txd to 0 at the clock edge, go to START.
  - START: txd = 0 for CLK_PER_BIT cycles. Then load txd with shift[0], set bit counter = 0, go to DATA.
  - DATA: each bit is held CLK_PER_BIT cycles. At each bit end, shift right and increment the bit counter. After bit DATA_BITWIDTH-1, set txd = 1 and go to STOP.
  - STOP: txd = 1 for CLK_PER_BIT cycles. At the last cycle, increment tx_count and go to IDLE.
- fifo_read_enable is asserted only in POP. It is never asserted while fifo_read_ready = 0, and never on two consecutive cycles.
- Latency: if IDLE sees ready & enable at cycle t, the pop strobe is at t+1 and the falling start edge is at t+3.
- Frame length is exactly (DATA_BITWIDTH+2)*CLK_PER_BIT cycles of start/data/stop.
- Back-to-back frames are separated by exactly 3 extra idle-high cycles (IDLE, POP, LOAD).
- Baud counter width is $clog2(CLK_PER_BIT). It counts 0..CLK_PER_BIT-1 and resets at each bit boundary; there is no drift across a frame.
- Bit counter width is $clog2(DATA_BITWIDTH)+1.
- tx_enable is sampled only in IDLE. Deasserting it in any other state has no effect on the current frame.
- txd is a registered output (no combinational path to the pin).
- tx_count wraps from 0xFFFF to 0x0000.

Test Plan:
- CLK_PER_BIT=4, FIFO holds 0x55, tx_enable=1 -> one pop pulse. txd holds 0 for 4 cycles, then 1,0,1,0,1,0,1,0 each for 4 cycles, then 1 for 4 cycles. tx_count = 1 and busy = 0 afterwards.
- CLK_PER_BIT=4, FIFO holds 0xA3 then 0x0F -> the two frames decode LSB first to 0xA3 and 0x0F. The gap from the end of the first stop bit to the second start edge is exactly 3 cycles. There are exactly 2 pop pulses and tx_count = 2.
- FIFO empty with tx_enable=1 for 100 cycles -> fifo_read_enable never asserted, txd = 1, busy = 0.
- tx_enable dropped to 0 in the middle of DATA of frame 0x81 with more bytes queued -> 0x81 completes with its stop bit, then no further pop occurs until tx_enable returns to 1.
- reset_n pulsed low during bit 3 of frame 0xC4 -> txd = 1 and busy = 0 asynchronously, tx_count = 0. After release with the FIFO non-empty, the next byte transmits normally.
- Preload tx_count to 0xFFFF via 65535 frames (or a force), then send 1 frame -> tx_count = 0x0000.
